// File: rtl/alu_fsm_pkg.sv
// Shared types and helpers for the condition-code / branch-decision controller.
// The N/Z/P encodings match the datapath's state_out debug vector.
package alu_fsm_pkg;

    typedef enum logic [2:0] {
        CC_IDLE = 3'b000,
        CC_N    = 3'b100,
        CC_Z    = 3'b010,
        CC_P    = 3'b001
    } cc_t;

    typedef enum logic {
        PH_FSM = 1'b0,
        PH_PC  = 1'b1
    } phase_t;

    localparam int SO_PHASE_BIT = 3;
    localparam int SO_N_BIT     = 2;
    localparam int SO_Z_BIT     = 1;
    localparam int SO_P_BIT     = 0;

    // Priority N > Z > P; with no flag set the current code is kept.
    function automatic cc_t cc_load(input cc_t cur, input logic n, input logic z, input logic p);
        cc_t res;
        if (n) begin
            res = CC_N;
        end else if (z) begin
            res = CC_Z;
        end else if (p) begin
            res = CC_P;
        end else begin
            res = cur;
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_fsm_nzp_match.sv
// Combinational branch-condition match: decoder mask against held code, gated by br.
// Shared with the decoder's branch unit, so kept as its own block.
module alu_fsm_nzp_match
    import alu_fsm_pkg::*;
(
    input  logic       i_br,
    input  logic [2:0] i_dec,
    input  cc_t        i_cc,
    output logic       o_taken
);

    logic [2:0] w_cc_bits;

    assign w_cc_bits = i_cc;

    // IDLE has no bit set, so it can never produce a taken branch.
    always_comb begin
        o_taken = 1'b0;
        if (i_br) begin
            o_taken = |(i_dec & w_cc_bits);
        end else begin
            o_taken = 1'b0;
        end
    end

endmodule

// File: rtl/alu_fsm.sv
// Condition-code and branch-decision controller alternating PC and FSM cycles.
// Codes latch on FSM edges; branch decisions use the code held before that edge.
module alu_fsm
    import alu_fsm_pkg::*;
(
    input  logic       clka,
    input  logic       reset_in,
    input  logic       n_dec_in,
    input  logic       z_dec_in,
    input  logic       p_dec_in,
    input  logic       n_alu_in,
    input  logic       z_alu_in,
    input  logic       p_alu_in,
    input  logic       we_reg_in,
    input  logic       br_in,
    output logic       pc_ctl_0_out,
    output logic       pc_latch_clkedge,
    output logic [3:0] state_out
);

    phase_t     r_phase;
    cc_t        r_cc;
    logic       r_pc_ctl;
    logic       w_taken;
    logic [2:0] w_dec;
    logic [2:0] w_cc_bits;

    assign w_dec = {n_dec_in, z_dec_in, p_dec_in};

    alu_fsm_nzp_match u_nzp_match (
        .i_br    (br_in),
        .i_dec   (w_dec),
        .i_cc    (r_cc),
        .o_taken (w_taken)
    );

    // Phase sequencer, condition-code latch and registered PC-select.
    always_ff @(posedge clka) begin
        if (!reset_in) begin
            r_phase  <= PH_PC;
            r_cc     <= CC_IDLE;
            r_pc_ctl <= 1'b0;
        end else begin
            case (r_phase)
                PH_PC: begin
                    r_phase  <= PH_FSM;
                    r_pc_ctl <= 1'b0;
                end
                PH_FSM: begin
                    r_phase  <= PH_PC;
                    r_pc_ctl <= w_taken;
                    if (we_reg_in) begin
                        r_cc <= cc_load(r_cc, n_alu_in, z_alu_in, p_alu_in);
                    end else begin
                        r_cc <= r_cc;
                    end
                end
                default: begin
                    r_phase  <= PH_PC;
                    r_cc     <= CC_IDLE;
                    r_pc_ctl <= 1'b0;
                end
            endcase
        end
    end

    assign w_cc_bits        = r_cc;
    assign pc_ctl_0_out     = r_pc_ctl;
    assign pc_latch_clkedge = (r_phase == PH_PC);

    assign state_out[SO_PHASE_BIT] = (r_phase == PH_PC);
    assign state_out[SO_N_BIT]     = w_cc_bits[2];
    assign state_out[SO_Z_BIT]     = w_cc_bits[1];
    assign state_out[SO_P_BIT]     = w_cc_bits[0];

endmodule

// File: tb/tb_alu_fsm.sv
// Scoreboard bench for alu_fsm: each edge's expected outputs are queued when
// the stimulus is applied and compared against the DUT just after the edge.
module tb_alu_fsm;

    logic       clka = 1'b0;
    logic       reset_in = 1'b0;
    logic       n_dec_in = 1'b0, z_dec_in = 1'b0, p_dec_in = 1'b0;
    logic       n_alu_in = 1'b0, z_alu_in = 1'b0, p_alu_in = 1'b0;
    logic       we_reg_in = 1'b0;
    logic       br_in = 1'b0;
    logic       pc_ctl_0_out;
    logic       pc_latch_clkedge;
    logic [3:0] state_out;

    int total = 0;
    int bad = 0;

    // Reference state: independent model of the documented behaviour.
    logic       m_phase_pc = 1'b1;
    logic [2:0] m_cc = 3'b000;
    logic       m_pc_ctl = 1'b0;

    logic [5:0] sb_q[$];

    alu_fsm dut (
        .clka             (clka),
        .reset_in         (reset_in),
        .n_dec_in         (n_dec_in),
        .z_dec_in         (z_dec_in),
        .p_dec_in         (p_dec_in),
        .n_alu_in         (n_alu_in),
        .z_alu_in         (z_alu_in),
        .p_alu_in         (p_alu_in),
        .we_reg_in        (we_reg_in),
        .br_in            (br_in),
        .pc_ctl_0_out     (pc_ctl_0_out),
        .pc_latch_clkedge (pc_latch_clkedge),
        .state_out        (state_out)
    );

    always #5 clka = ~clka;

    task automatic check_eq(input string tag, input logic [5:0] got, input logic [5:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got pc_ctl/latch/state=%b required=%b", tag, got, exp);
        end
    endtask

    // One clock edge: drive inputs, queue the model's post-edge outputs, compare.
    task automatic step(input string tag, input logic rst, input logic we,
                        input logic [2:0] alu, input logic br, input logic [2:0] dec);
        logic       taken;
        logic [5:0] exp;
        logic [5:0] got;
        reset_in  = rst;
        we_reg_in = we;
        {n_alu_in, z_alu_in, p_alu_in} = alu;
        br_in = br;
        {n_dec_in, z_dec_in, p_dec_in} = dec;

        if (!rst) begin
            m_phase_pc = 1'b1;
            m_cc       = 3'b000;
            m_pc_ctl   = 1'b0;
        end else if (m_phase_pc) begin
            m_phase_pc = 1'b0;
            m_pc_ctl   = 1'b0;
        end else begin
            taken = br & ((dec[2] & m_cc[2]) | (dec[1] & m_cc[1]) | (dec[0] & m_cc[0]));
            if (we) begin
                if (alu[2])      m_cc = 3'b100;
                else if (alu[1]) m_cc = 3'b010;
                else if (alu[0]) m_cc = 3'b001;
            end
            m_pc_ctl   = taken;
            m_phase_pc = 1'b1;
        end
        exp = {m_pc_ctl, m_phase_pc, m_phase_pc, m_cc};
        sb_q.push_back(exp);

        @(posedge clka);
        #1;
        got = {pc_ctl_0_out, pc_latch_clkedge, state_out};
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, got, 6'h3f ^ got);
        end else begin
            check_eq(tag, got, sb_q.pop_front());
        end
    endtask

    // PC edge then FSM edge, starting in a PC cycle.
    task automatic pair(input string tag, input logic pc_we, input logic [2:0] pc_alu,
                        input logic fsm_we, input logic [2:0] fsm_alu,
                        input logic br, input logic [2:0] dec);
        step({tag, "_pc"},  1'b1, pc_we,  pc_alu,  br, dec);
        step({tag, "_fsm"}, 1'b1, fsm_we, fsm_alu, br, dec);
    endtask

    initial begin
        step("rst0", 1'b0, 1'b1, 3'b111, 1'b1, 3'b111);
        step("rst1", 1'b0, 1'b1, 3'b100, 1'b1, 3'b111);

        pair("we0_n", 1'b0, 3'b100, 1'b0, 3'b100, 1'b0, 3'b000);
        pair("we0_z", 1'b0, 3'b010, 1'b0, 3'b010, 1'b0, 3'b000);
        pair("we0_p", 1'b0, 3'b001, 1'b0, 3'b001, 1'b0, 3'b000);

        pair("pc_only_n", 1'b1, 3'b100, 1'b0, 3'b000, 1'b0, 3'b000);
        pair("load_n",    1'b0, 3'b000, 1'b1, 3'b100, 1'b0, 3'b000);
        pair("br_n",      1'b0, 3'b000, 1'b0, 3'b000, 1'b1, 3'b100);
        pair("after_br_n", 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000);
        pair("nobr_br0",  1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 3'b100);
        pair("nobr_n_zp", 1'b0, 3'b000, 1'b0, 3'b000, 1'b1, 3'b011);

        pair("pc_only_z", 1'b1, 3'b010, 1'b0, 3'b000, 1'b0, 3'b000);
        pair("load_zp",   1'b0, 3'b000, 1'b1, 3'b011, 1'b0, 3'b000);
        pair("br_z",      1'b0, 3'b000, 1'b0, 3'b000, 1'b1, 3'b010);
        pair("nobr_z_p",  1'b0, 3'b000, 1'b0, 3'b000, 1'b1, 3'b001);

        pair("pc_only_p", 1'b1, 3'b001, 1'b0, 3'b000, 1'b0, 3'b000);
        pair("load_p",    1'b0, 3'b000, 1'b1, 3'b001, 1'b0, 3'b000);
        pair("br_p",      1'b0, 3'b000, 1'b0, 3'b000, 1'b1, 3'b001);
        pair("nobr_p_n",  1'b0, 3'b000, 1'b0, 3'b000, 1'b1, 3'b100);
        pair("we1_none",  1'b0, 3'b000, 1'b1, 3'b000, 1'b1, 3'b001);

        // Same-edge write must not steer that edge's branch.
        pair("load_nzp_br_n", 1'b0, 3'b000, 1'b1, 3'b111, 1'b1, 3'b100);
        pair("br_n_late",     1'b0, 3'b000, 1'b0, 3'b000, 1'b1, 3'b100);

        step("mid_pc",  1'b1, 1'b0, 3'b000, 1'b0, 3'b000);
        step("mid_rst", 1'b0, 1'b1, 3'b001, 1'b1, 3'b111);
        pair("idle_br_a", 1'b0, 3'b000, 1'b0, 3'b000, 1'b1, 3'b111);
        pair("idle_br_b", 1'b0, 3'b000, 1'b0, 3'b000, 1'b1, 3'b111);

        for (int i = 0; i < 60; i++) begin
            step("rand", ($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end

        if (sb_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL sb_leftover: got %0d entries required 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
